// File: rtl/fft_sdf_stage_ctrl.sv
// rtl/fft_sdf_stage_ctrl.sv - R2SDF FFT stage sequencer: counter, twiddle address, feedback delay, drain.
module fft_sdf_stage_ctrl #(
  parameter int IN_W     = 24,
  parameter int LOG2_D   = 1,
  parameter int TW_AW    = 10,
  parameter int TW_SHIFT = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [IN_W-1:0] din_r_i,
  input  logic signed [IN_W-1:0] din_i_i,
  input  logic                   flush_i,
  output logic                   bf_state_o,
  output logic signed [IN_W-1:0] bf_ar_o,
  output logic signed [IN_W-1:0] bf_ai_o,
  output logic signed [IN_W-1:0] bf_br_o,
  output logic signed [IN_W-1:0] bf_bi_o,
  input  logic signed [IN_W-1:0] bf_dout_ar_i,
  input  logic signed [IN_W-1:0] bf_dout_ai_i,
  input  logic signed [IN_W-1:0] bf_dout_br_i,
  input  logic signed [IN_W-1:0] bf_dout_bi_i,
  output logic [TW_AW-1:0]       tw_addr_o,
  output logic signed [IN_W-1:0] dout_r_o,
  output logic signed [IN_W-1:0] dout_i_o,
  output logic                   out_valid_o,
  output logic                   busy_o
);

  localparam int D       = 1 << LOG2_D;
  localparam int TW_FULL = LOG2_D + TW_SHIFT;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LOG2_D:0]       cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic signed [IN_W-1:0] dly_r_q [D];
  logic signed [IN_W-1:0] dly_i_q [D];
  logic signed [IN_W-1:0] dout_r_q, dout_i_q;
  logic                  out_valid_q;

  logic [LOG2_D-1:0]     ptr;
  logic                  half;
  logic                  step;
  logic [TW_FULL-1:0]    tw_wide;

  assign ptr  = cnt_q[LOG2_D-1:0];
  assign half = cnt_q[LOG2_D];

  assign in_ready_o = (state_q == S_RUN);
  assign busy_o     = (state_q == S_FLUSH);
  assign step       = busy_o | (in_valid_i & in_ready_o);

  assign bf_state_o = ~half;
  assign tw_wide    = TW_FULL'(ptr) << TW_SHIFT;
  assign tw_addr_o  = TW_AW'(tw_wide);

  // Drain feeds zeros so the delayed sums are pushed out unchanged.
  assign bf_ar_o = busy_o ? '0 : din_r_i;
  assign bf_ai_o = busy_o ? '0 : din_i_i;
  assign bf_br_o = dly_r_q[ptr];
  assign bf_bi_o = dly_i_q[ptr];

  assign dout_r_o    = dout_r_q;
  assign dout_i_o    = dout_i_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (step) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_RUN: begin
        if (step && (cnt_q == '1)) begin
          primed_d = 1'b1;
        end
        if (flush_i && !in_valid_i && (cnt_q == '0) && primed_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (ptr == '1) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          primed_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < D; k++) begin
        dly_r_q[k] <= '0;
        dly_i_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      // State-1 outputs of the very first block carry no real sum yet.
      out_valid_q <= step & (~bf_state_o | primed_q);
      if (step) begin
        dly_r_q[ptr] <= bf_dout_br_i;
        dly_i_q[ptr] <= bf_dout_bi_i;
        dout_r_q     <= bf_dout_ar_i;
        dout_i_q     <= bf_dout_ai_i;
      end
    end
  end

endmodule

// File: doc/fft_sdf_stage_ctrl.md
# fft_sdf_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (R2SDF) FFT stage built around the combinational `fft_butterFly`. It owns the stage's sample counter, the butterfly `state` select, the twiddle-ROM address, the D-entry feedback delay line, the input handshake and the registered stage output. It also runs a drain (flush) sequence that empties the delay line after the last frame. One instance sits per stage; stages chain `dout`/`out_valid` into `din`/`in_valid`.

## Interface
- `IN_W`, 24: sample component width (signed).
- `LOG2_D`, 1: log2 of delay depth D = 2^LOG2_D; legal range 1..10.
- `TW_AW`, 10: twiddle ROM address width.
- `TW_SHIFT`, 0: stride shift applied to the in-half index to form `tw_addr`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  controller accepts input this cycle.
- `din_r`, `din_i`  in  IN_W  input sample.
- `flush`  in  1  drain request (level, sampled per cycle).
- `bf_state`  out  1  to butterfly `state`.
- `bf_ar`, `bf_ai`  out  IN_W  to butterfly `din_ar/ai`.
- `bf_br`, `bf_bi`  out  IN_W  to butterfly `din_br/bi` (delay-line head).
- `bf_dout_ar`, `bf_dout_ai`  in  IN_W  from butterfly `dout_ar/ai`.
- `bf_dout_br`, `bf_dout_bi`  in  IN_W  from butterfly `dout_br/bi` (written back to delay).
- `tw_addr`  out  TW_AW  twiddle ROM address; ROM supplies `W_R/W_I` combinationally.
- `dout_r`, `dout_i`  out  IN_W  registered stage output.
- `out_valid`  out  1  registered output qualifier.
- `busy`  out  1  high during FLUSH.

## Operation
- Counter `cnt`, LOG2_D+1 bits; `ptr` = `cnt[LOG2_D-1:0]`, `half` = `cnt[LOG2_D]`.
- `bf_state` = ~`half`: first D samples of each 2D block use state 1 (twiddle into delay, delayed sum out); next D use state 0 (sum into delay, difference out).
- `tw_addr` = (`ptr` << TW_SHIFT) truncated to TW_AW bits; combinational from `cnt`.
- Delay line: D entries of {re,im}, register array, cleared by reset. `bf_br/bi` = entry[`ptr`] combinationally; on each step, entry[`ptr`] <= `bf_dout_br/bi`.
- A "step" is an accepted input (`in_valid & in_ready`) or a FLUSH cycle. On a step: `cnt` increments (wraps mod 2D), delay is written, and `dout` <= `bf_dout_ar/ai`.
- `bf_ar/ai` = `din_r/i` in RUN, zero in FLUSH.
- `primed` flag: set when `cnt` wraps 2D-1 -> 0 on a step. Cleared by reset and at FLUSH end.
- `out_valid` next = step & (`bf_state`==0 | `primed`). State-1 outputs before the first complete block are suppressed.
- FSM RUN/FLUSH:
  - RUN: `in_ready`=1.
  - RUN -> FLUSH when `flush`=1, `in_valid`=0, `cnt`=0 and `primed`=1. Otherwise `flush` is ignored, and `in_valid` wins on a tie.
  - FLUSH: `in_ready`=0, `busy`=1. Executes exactly D steps in state 1 with zero input, then returns to RUN with `cnt`=0 and `primed`=0.
- No arithmetic inside the controller; widths pass through unchanged.

## Timing
- Reset values: `cnt`=0, FSM=RUN, `primed`=0, delay entries 0, `dout_r/i`=0, `out_valid`=0, `busy`=0, `in_ready`=1. `bf_state`=1 and `tw_addr`=0 follow from `cnt`.
- Latency: input accepted in cycle t -> its butterfly difference (state 0) appears on `dout` with `out_valid` at t+1. Its sum appears D steps later.
- Gaps in `in_valid` freeze `cnt`, the delay line and `dout`; `out_valid` drops to 0 for that cycle.
- FLUSH occupies D consecutive cycles; `in_valid` during FLUSH is not accepted.
- `rst` mid-frame or mid-FLUSH returns all state to reset values immediately (asynchronous); partial frame contents are discarded.

## Test plan
- Reset: assert `rst` mid-stream -> next cycle `out_valid`=0, `dout`=0, `in_ready`=1, `bf_state`=1, `tw_addr`=0.
- LOG2_D=1, butterfly instantiated, W=(0x10000,0), real inputs 1,2,3,4 back-to-back:
  - no `out_valid` for inputs 1,2;
  - `dout_r`=2,2 for inputs 3,4;
  - then `flush` -> `busy` for 2 cycles, `dout_r`=4,6 with `out_valid`.
- Two back-to-back blocks 1,2,3,4 then 5,6,7,8 with no flush:
  - during 5,6 outputs are 4,6 (`primed`);
  - during 7,8 outputs are 2,2.
- `in_valid` gap of 3 cycles between samples 2 and 3 -> outputs identical to the gapless run, `out_valid` low during the gap.
- `flush` asserted with `cnt`=1, or together with `in_valid` -> ignored, `busy` stays 0, sample accepted.
- LOG2_D=3, TW_SHIFT=2, TW_AW=4: `tw_addr` sequence 0,4,8,12,0,4,8,12 over ptr 0..7 (truncation wrap). Check that `tw_addr` holds during `in_valid` gaps.
